// File: rtl/axi_write_burst_driver.sv
// axi_write_burst_driver
//   Command-level front end for the AXI write path. Takes one write command
//   plus a beat stream and sequences it through the downstream write channel
//   as address phase, data phase and response phase. Illegal commands are
//   rejected, stalled phases time out, and one completion is reported per
//   command.
//
// Ports
//   clk, resetn                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready, cmd_*       command handshake and fields
//   dat_valid/dat_ready, dat_*       beat-stream handshake, data, strobes
//   aw_addr/len/size/burst, aw_valid latched command toward the write channel
//   axi_awready                      address accepted
//   w_data, w_strb, w_valid          beat pass-through toward the write channel
//   axi_wready                       beat accepted
//   b_ready, axi_bvalid, axi_bresp   response handshake
//   done_valid/resp/timeout          one-cycle completion report
//   txn_count                        completed-command counter (wraps)
module axi_write_burst_driver #(
  parameter int AW      = 32,
  parameter int DW      = 64,
  parameter int TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [7:0]      cmd_len,
  input  logic [2:0]      cmd_size,
  input  logic [1:0]      cmd_burst,
  input  logic            dat_valid,
  output logic            dat_ready,
  input  logic [DW-1:0]   dat_data,
  input  logic [DW/8-1:0] dat_strb,
  output logic [AW-1:0]   aw_addr,
  output logic [7:0]      aw_len,
  output logic [2:0]      aw_size,
  output logic [1:0]      aw_burst,
  output logic            aw_valid,
  input  logic            axi_awready,
  output logic [DW-1:0]   w_data,
  output logic [DW/8-1:0] w_strb,
  output logic            w_valid,
  input  logic            axi_wready,
  output logic            b_ready,
  input  logic            axi_bvalid,
  input  logic [1:0]      axi_bresp,
  output logic            done_valid,
  output logic [1:0]      done_resp,
  output logic            done_timeout,
  output logic [15:0]     txn_count
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_e;

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT);
  localparam bit          TMO_EN    = (TIMEOUT != 0);

  state_e        state_q, state_d;
  logic [AW-1:0] aw_addr_q, aw_addr_d;
  logic [7:0]    aw_len_q, aw_len_d;
  logic [2:0]    aw_size_q, aw_size_d;
  logic [1:0]    aw_burst_q, aw_burst_d;
  logic [8:0]    beat_cnt_q, beat_cnt_d;
  logic [15:0]   tmo_cnt_q, tmo_cnt_d;
  logic          done_valid_q, done_valid_d;
  logic [1:0]    done_resp_q, done_resp_d;
  logic          done_timeout_q, done_timeout_d;
  logic [15:0]   txn_count_q, txn_count_d;

  logic          tmo_fire;
  logic          aw_hs, w_hs, b_hs;
  logic [AW:0]   burst_bytes, burst_end;
  logic          cross_4k, cmd_illegal;

  // Legality of the incoming command. The end address is formed one bit
  // wider than the address so a wrap past the top of memory shows as a carry.
  always_comb begin
    burst_bytes = {{(AW-8){1'b0}}, ({1'b0, cmd_len} + 9'd1)} << cmd_size;
    burst_end   = {1'b0, cmd_addr} + burst_bytes - (AW+1)'(1);
    cross_4k    = burst_end[AW] || (burst_end[AW-1:12] != cmd_addr[AW-1:12]);
    cmd_illegal = (cmd_size > 3'd3) || ((cmd_burst == 2'b01) && cross_4k);
  end

  // Timeout takes priority over any handshake: all valids/readies drop in
  // the cycle it fires, so nothing can complete in that cycle.
  assign tmo_fire = TMO_EN && (state_q != S_IDLE) && (tmo_cnt_q == TMO_LIMIT);

  assign aw_hs = aw_valid && axi_awready;
  assign w_hs  = w_valid && axi_wready;
  assign b_hs  = b_ready && axi_bvalid;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (cmd_valid) state_d = cmd_illegal ? S_IDLE : S_ADDR;
      S_ADDR: begin
        if (tmo_fire)   state_d = S_IDLE;
        else if (aw_hs) state_d = S_DATA;
      end
      S_DATA: begin
        if (tmo_fire)                                    state_d = S_IDLE;
        else if (w_hs && (beat_cnt_q == {1'b0, aw_len_q})) state_d = S_RESP;
      end
      S_RESP: begin
        if (tmo_fire || b_hs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    cmd_ready    = resetn && (state_q == S_IDLE);
    aw_valid     = (state_q == S_ADDR) && !tmo_fire;
    w_valid      = (state_q == S_DATA) && !tmo_fire && dat_valid;
    dat_ready    = (state_q == S_DATA) && !tmo_fire && axi_wready;
    b_ready      = (state_q == S_RESP) && !tmo_fire;
    w_data       = (state_q == S_DATA) ? dat_data : '0;
    w_strb       = (state_q == S_DATA) ? dat_strb : '0;
    aw_addr      = aw_addr_q;
    aw_len       = aw_len_q;
    aw_size      = aw_size_q;
    aw_burst     = aw_burst_q;
    done_valid   = done_valid_q;
    done_resp    = done_resp_q;
    done_timeout = done_timeout_q;
    txn_count    = txn_count_q;
  end

  // Datapath next values
  always_comb begin
    aw_addr_d      = aw_addr_q;
    aw_len_d       = aw_len_q;
    aw_size_d      = aw_size_q;
    aw_burst_d     = aw_burst_q;
    beat_cnt_d     = beat_cnt_q;
    done_valid_d   = 1'b0;
    done_resp_d    = done_resp_q;
    done_timeout_d = done_timeout_q;
    txn_count_d    = txn_count_q;

    if ((state_q == S_IDLE) && cmd_valid) begin
      aw_addr_d  = cmd_addr;
      aw_len_d   = cmd_len;
      aw_size_d  = cmd_size;
      aw_burst_d = cmd_burst;
      if (cmd_illegal) begin
        done_valid_d   = 1'b1;
        done_resp_d    = 2'b10;
        done_timeout_d = 1'b0;
      end
    end

    if (aw_hs) beat_cnt_d = '0;
    if (w_hs)  beat_cnt_d = beat_cnt_q + 9'd1;

    if (b_hs) begin
      done_valid_d   = 1'b1;
      done_resp_d    = axi_bresp;
      done_timeout_d = 1'b0;
      txn_count_d    = txn_count_q + 16'd1;
    end

    if (tmo_fire) begin
      done_valid_d   = 1'b1;
      done_resp_d    = 2'b11;
      done_timeout_d = 1'b1;
    end

    // Idle counter restarts on any phase change or handshake.
    if ((state_d != state_q) || aw_hs || w_hs || b_hs) tmo_cnt_d = '0;
    else if (state_q != S_IDLE)                          tmo_cnt_d = tmo_cnt_q + 16'd1;
    else                                                 tmo_cnt_d = tmo_cnt_q;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_addr_q      <= '0;
      aw_len_q       <= '0;
      aw_size_q      <= '0;
      aw_burst_q     <= '0;
      beat_cnt_q     <= '0;
      tmo_cnt_q      <= '0;
      done_valid_q   <= 1'b0;
      done_resp_q    <= '0;
      done_timeout_q <= 1'b0;
      txn_count_q    <= '0;
    end else begin
      aw_addr_q      <= aw_addr_d;
      aw_len_q       <= aw_len_d;
      aw_size_q      <= aw_size_d;
      aw_burst_q     <= aw_burst_d;
      beat_cnt_q     <= beat_cnt_d;
      tmo_cnt_q      <= tmo_cnt_d;
      done_valid_q   <= done_valid_d;
      done_resp_q    <= done_resp_d;
      done_timeout_q <= done_timeout_d;
      txn_count_q    <= txn_count_d;
    end
  end

endmodule

// File: tb/tb_axi_write_burst_driver.sv
// Directed testbench for axi_write_burst_driver (TIMEOUT set to 8).
module tb_axi_write_burst_driver;

  localparam int AW = 32;
  localparam int DW = 64;

  logic            clk;
  logic            resetn;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [AW-1:0]   cmd_addr;
  logic [7:0]      cmd_len;
  logic [2:0]      cmd_size;
  logic [1:0]      cmd_burst;
  logic            dat_valid;
  logic            dat_ready;
  logic [DW-1:0]   dat_data;
  logic [DW/8-1:0] dat_strb;
  logic [AW-1:0]   aw_addr;
  logic [7:0]      aw_len;
  logic [2:0]      aw_size;
  logic [1:0]      aw_burst;
  logic            aw_valid;
  logic            axi_awready;
  logic [DW-1:0]   w_data;
  logic [DW/8-1:0] w_strb;
  logic            w_valid;
  logic            axi_wready;
  logic            b_ready;
  logic            axi_bvalid;
  logic [1:0]      axi_bresp;
  logic            done_valid;
  logic [1:0]      done_resp;
  logic            done_timeout;
  logic [15:0]     txn_count;

  int errors = 0;
  int checks = 0;

  axi_write_burst_driver #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_data(dat_data), .dat_strb(dat_strb),
    .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
    .aw_valid(aw_valid), .axi_awready(axi_awready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .axi_wready(axi_wready),
    .b_ready(b_ready), .axi_bvalid(axi_bvalid), .axi_bresp(axi_bresp),
    .done_valid(done_valid), .done_resp(done_resp), .done_timeout(done_timeout),
    .txn_count(txn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a command for one cycle; returns one cycle after the handshake.
  task automatic send_cmd(input logic [AW-1:0] a, input logic [7:0] l,
                          input logic [2:0] s, input logic [1:0] b);
    cmd_addr  = a;
    cmd_len   = l;
    cmd_size  = s;
    cmd_burst = b;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  // From the first ADDR cycle with all readies high: AW, nbeats of W, then B.
  // Returns in the cycle after the B handshake.
  task automatic complete_legal(input int nbeats, input logic [1:0] resp);
    step();
    for (int b = 0; b < nbeats; b++) begin
      dat_data = 64'hD000_0000_0000_0000 | 64'(b);
      step();
    end
    axi_bvalid = 1'b1;
    axi_bresp  = resp;
    step();
    axi_bvalid = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    cmd_valid = 1'b1;
    step();
    step();
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 0", cmd_ready); end
    checks++; if (aw_valid !== 1'b0) begin errors++; $display("FAIL reset_aw_valid: got %b expected 0", aw_valid); end
    checks++; if (dat_ready !== 1'b0) begin errors++; $display("FAIL reset_dat_ready: got %b expected 0", dat_ready); end
    checks++; if (done_valid !== 1'b0) begin errors++; $display("FAIL reset_done_valid: got %b expected 0", done_valid); end
    checks++; if (txn_count !== 16'd0) begin errors++; $display("FAIL reset_txn_count: got %0d expected 0", txn_count); end
    cmd_valid = 1'b0;
    resetn = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_cmd_ready: got %b expected 1", cmd_ready); end
    step();
    $display("txn reset: done");
  endtask

  task automatic test_single_beat();
    cmd_addr = 32'h1000; cmd_len = 8'd0; cmd_size = 3'd3; cmd_burst = 2'b01;
    cmd_valid = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL single_cmd_ready_T: got %b expected 1", cmd_ready); end
    step(); // T+1
    cmd_valid = 1'b0;
    dat_data = 64'h1122_3344_5566_7788;
    dat_strb = 8'hA5;
    #1;
    checks++; if (aw_valid !== 1'b1) begin errors++; $display("FAIL single_aw_valid_T1: got %b expected 1", aw_valid); end
    checks++; if ({aw_addr, aw_len, aw_size, aw_burst} !== {32'h1000, 8'd0, 3'd3, 2'b01})
      begin errors++; $display("FAIL single_aw_fields: got %h/%h/%h/%h expected 1000/00/3/1", aw_addr, aw_len, aw_size, aw_burst); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL single_cmd_ready_busy: got %b expected 0", cmd_ready); end
    checks++; if (w_valid !== 1'b0) begin errors++; $display("FAIL single_w_valid_in_addr: got %b expected 0", w_valid); end
    step(); // T+2
    checks++; if (w_valid !== 1'b1) begin errors++; $display("FAIL single_w_valid_T2: got %b expected 1", w_valid); end
    checks++; if (w_data !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL single_w_data: got %h expected 1122334455667788", w_data); end
    checks++; if (w_strb !== 8'hA5) begin errors++; $display("FAIL single_w_strb: got %h expected a5", w_strb); end
    checks++; if (aw_valid !== 1'b0) begin errors++; $display("FAIL single_aw_drop: got %b expected 0", aw_valid); end
    step(); // T+3
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL single_b_ready_T3: got %b expected 1", b_ready); end
    checks++; if (w_valid !== 1'b0) begin errors++; $display("FAIL single_w_valid_in_resp: got %b expected 0", w_valid); end
    axi_bvalid = 1'b1; axi_bresp = 2'b00;
    step(); // T+4
    axi_bvalid = 1'b0;
    checks++; if (done_valid !== 1'b1) begin errors++; $display("FAIL single_done_T4: got %b expected 1", done_valid); end
    checks++; if ({done_resp, done_timeout} !== 3'b000) begin errors++; $display("FAIL single_done_resp: got %b/%b expected 00/0", done_resp, done_timeout); end
    checks++; if (txn_count !== 16'd1) begin errors++; $display("FAIL single_txn_count: got %0d expected 1", txn_count); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL single_cmd_ready_R1: got %b expected 1", cmd_ready); end
    step();
    checks++; if (done_valid !== 1'b0) begin errors++; $display("FAIL single_done_pulse_width: got %b expected 0", done_valid); end
    $display("txn single: addr=1000 len=0 resp=%b count=%0d", done_resp, txn_count);
  endtask

  task automatic test_burst16();
    int nhs;
    bit early_resp;
    logic [63:0] exp_data;
    nhs = 0;
    early_resp = 1'b0;
    send_cmd(32'h2000, 8'd15, 3'd3, 2'b01);
    checks++; if (aw_valid !== 1'b1) begin errors++; $display("FAIL burst_aw_valid: got %b expected 1", aw_valid); end
    step(); // first DATA cycle
    for (int c = 0; c < 200 && nhs < 16; c++) begin
      axi_wready = (c % 2 == 0);
      dat_valid  = (c % 3 != 2);
      exp_data   = 64'hA5A5_0000_0000_0000 | 64'(nhs);
      dat_data   = exp_data;
      #1;
      if (b_ready) early_resp = 1'b1;
      if (w_valid && axi_wready) begin
        checks++; if (w_data !== exp_data) begin errors++; $display("FAIL burst_w_data_beat%0d: got %h expected %h", nhs, w_data, exp_data); end
        nhs++;
      end
      step();
    end
    checks++; if (nhs !== 16) begin errors++; $display("FAIL burst_hs_count: got %0d expected 16", nhs); end
    checks++; if (early_resp !== 1'b0) begin errors++; $display("FAIL burst_early_resp: got %b expected 0", early_resp); end
    dat_valid = 1'b1;
    axi_wready = 1'b1;
    #1;
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL burst_b_ready_L1: got %b expected 1", b_ready); end
    checks++; if (w_valid !== 1'b0) begin errors++; $display("FAIL burst_extra_beat: got %b expected 0", w_valid); end
    axi_bvalid = 1'b1; axi_bresp = 2'b01;
    step();
    axi_bvalid = 1'b0;
    checks++; if ({done_valid, done_resp} !== 3'b101) begin errors++; $display("FAIL burst_done: got %b/%b expected 1/01", done_valid, done_resp); end
    checks++; if (txn_count !== 16'd2) begin errors++; $display("FAIL burst_txn_count: got %0d expected 2", txn_count); end
    $display("txn burst16: beats=%0d resp=%b count=%0d", nhs, done_resp, txn_count);
  endtask

  task automatic test_4k_boundary();
    send_cmd(32'h0FF8, 8'd1, 3'd3, 2'b01);
    checks++; if ({done_valid, done_resp, done_timeout} !== 4'b1100) begin errors++; $display("FAIL 4k_reject_done: got %b/%b/%b expected 1/10/0", done_valid, done_resp, done_timeout); end
    checks++; if (aw_valid !== 1'b0) begin errors++; $display("FAIL 4k_reject_aw_valid: got %b expected 0", aw_valid); end
    checks++; if (txn_count !== 16'd2) begin errors++; $display("FAIL 4k_reject_txn_count: got %0d expected 2", txn_count); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL 4k_reject_cmd_ready: got %b expected 1", cmd_ready); end
    step();
    checks++; if ({aw_valid, done_valid} !== 2'b00) begin errors++; $display("FAIL 4k_reject_after: got aw=%b done=%b expected 0/0", aw_valid, done_valid); end
    $display("txn 4k_incr: rejected resp=%b", done_resp);
    send_cmd(32'h0FF8, 8'd1, 3'd3, 2'b00);
    checks++; if ({aw_valid, done_valid} !== 2'b10) begin errors++; $display("FAIL 4k_fixed_issue: got aw=%b done=%b expected 1/0", aw_valid, done_valid); end
    complete_legal(2, 2'b00);
    checks++; if ({done_valid, done_resp} !== 3'b100) begin errors++; $display("FAIL 4k_fixed_done: got %b/%b expected 1/00", done_valid, done_resp); end
    checks++; if (txn_count !== 16'd3) begin errors++; $display("FAIL 4k_fixed_txn_count: got %0d expected 3", txn_count); end
    $display("txn 4k_fixed: resp=%b count=%0d", done_resp, txn_count);
  endtask

  task automatic test_size_limits();
    send_cmd(32'h0000, 8'd0, 3'd4, 2'b01);
    checks++; if ({done_valid, done_resp} !== 3'b110) begin errors++; $display("FAIL size4_reject: got %b/%b expected 1/10", done_valid, done_resp); end
    checks++; if (aw_valid !== 1'b0) begin errors++; $display("FAIL size4_aw_valid: got %b expected 0", aw_valid); end
    $display("txn size4: rejected resp=%b", done_resp);
    step();
    send_cmd(32'h0000, 8'd255, 3'd3, 2'b01);
    checks++; if ({aw_valid, done_valid} !== 2'b10) begin errors++; $display("FAIL len255_issue: got aw=%b done=%b expected 1/0", aw_valid, done_valid); end
    complete_legal(256, 2'b00);
    checks++; if ({done_valid, done_resp} !== 3'b100) begin errors++; $display("FAIL len255_done: got %b/%b expected 1/00", done_valid, done_resp); end
    checks++; if (txn_count !== 16'd4) begin errors++; $display("FAIL len255_txn_count: got %0d expected 4", txn_count); end
    $display("txn len255: resp=%b count=%0d", done_resp, txn_count);
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    axi_awready = 1'b0;
    send_cmd(32'h5000, 8'd0, 3'd3, 2'b01);
    for (int i = 0; i < 20; i++) begin
      if (!aw_valid) break;
      n++;
      step();
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL timeout_aw_cycles: got %0d expected 8", n); end
    checks++; if (done_valid !== 1'b0) begin errors++; $display("FAIL timeout_done_early: got %b expected 0", done_valid); end
    step();
    axi_awready = 1'b1;
    checks++; if ({done_valid, done_resp, done_timeout} !== 4'b1111) begin errors++; $display("FAIL timeout_done: got %b/%b/%b expected 1/11/1", done_valid, done_resp, done_timeout); end
    checks++; if (txn_count !== 16'd4) begin errors++; $display("FAIL timeout_txn_count: got %0d expected 4", txn_count); end
    checks++; if ({cmd_ready, aw_valid} !== 2'b10) begin errors++; $display("FAIL timeout_idle: got ready=%b aw=%b expected 1/0", cmd_ready, aw_valid); end
    step();
    checks++; if ({done_valid, done_resp, done_timeout} !== 4'b0111) begin errors++; $display("FAIL timeout_hold: got %b/%b/%b expected 0/11/1", done_valid, done_resp, done_timeout); end
    $display("txn timeout: aw_cycles=%0d resp=%b", n, done_resp);
  endtask

  task automatic test_reset_mid_data();
    bit saw_done;
    saw_done = 1'b0;
    send_cmd(32'h3000, 8'd7, 3'd3, 2'b01);
    step(); // beat 1
    step(); // beat 2
    step(); // beat 3 presented
    checks++; if (w_valid !== 1'b1) begin errors++; $display("FAIL rstmid_in_data: got %b expected 1", w_valid); end
    resetn = 1'b0;
    #1;
    checks++; if ({w_valid, dat_ready, aw_valid, b_ready, cmd_ready} !== 5'b00000)
      begin errors++; $display("FAIL rstmid_outputs: got w=%b dr=%b aw=%b b=%b cr=%b expected all 0", w_valid, dat_ready, aw_valid, b_ready, cmd_ready); end
    checks++; if ({w_data, txn_count} !== 80'd0) begin errors++; $display("FAIL rstmid_data_count: got %h/%0d expected 0/0", w_data, txn_count); end
    for (int i = 0; i < 4; i++) begin
      if (done_valid) saw_done = 1'b1;
      if (i == 1) resetn = 1'b1;
      step();
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL rstmid_no_done: got %b expected 0", saw_done); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_cmd_ready: got %b expected 1", cmd_ready); end
    send_cmd(32'h4000, 8'd0, 3'd3, 2'b01);
    complete_legal(1, 2'b00);
    checks++; if ({done_valid, done_resp} !== 3'b100) begin errors++; $display("FAIL rstmid_new_done: got %b/%b expected 1/00", done_valid, done_resp); end
    checks++; if (txn_count !== 16'd1) begin errors++; $display("FAIL rstmid_new_count: got %0d expected 1", txn_count); end
    $display("txn after_reset: resp=%b count=%0d", done_resp, txn_count);
  endtask

  initial begin
    resetn = 1'b0;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_burst = '0;
    dat_valid = 1'b1; dat_data = '0; dat_strb = 8'hFF;
    axi_awready = 1'b1; axi_wready = 1'b1; axi_bvalid = 1'b0; axi_bresp = 2'b00;
    #2;
    test_reset();
    test_single_beat();
    test_burst16();
    test_4k_boundary();
    test_size_limits();
    test_timeout();
    test_reset_mid_data();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi_write_burst_driver.md
# axi_write_burst_driver

Command-level front end for the AXI write path. It accepts one write command (address, length, size, burst) and a 64-bit beat stream, then drives the address, data and response-ready inputs of the downstream write channel. It counts beats, rejects illegal commands, times out stalled transactions, and reports one completion per command. It sits directly upstream of the write channel: its aw_*/w_*/b_ready outputs feed that block's awaddr_in/…/bready_in, and its axi_* inputs come from that block's outputs.

## Interface
- AW, 32, address width
- DW, 64, data width (strobe width DW/8; only 64 supported)
- TIMEOUT, 1024, max idle cycles per phase; 0 disables; counter is 16 bits
- clk  in  1  clock, all logic on rising edge
- resetn  in  1  asynchronous active-low reset
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_addr  in  AW  start byte address
- cmd_len  in  8  beats minus one
- cmd_size  in  3  log2 bytes per beat
- cmd_burst  in  2  burst type
- dat_valid / dat_ready  in / out  1  beat-stream handshake
- dat_data  in  DW  beat data
- dat_strb  in  DW/8  beat strobes
- aw_addr, aw_len, aw_size, aw_burst  out  AW/8/3/2  latched command fields
- aw_valid  out  1  address valid
- axi_awready  in  1  address accepted
- w_data, w_strb  out  DW/DW/8  beat data and strobes
- w_valid  out  1  data valid
- axi_wready  in  1  data accepted
- b_ready  out  1  response ready
- axi_bvalid  in  1  response valid
- axi_bresp  in  2  response code
- done_valid  out  1  one-cycle completion pulse
- done_resp  out  2  final response code
- done_timeout  out  1  completion was caused by timeout
- txn_count  out  16  completed commands, wraps at 65535→0

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- **IDLE**
  - cmd_ready=1.
  - On cmd_valid: latch all cmd fields.
  - Legality check. A command is illegal if either:
    - cmd_size>3; or
    - cmd_burst==2'b01 (INCR) and the burst crosses 4 KB.
  - 4 KB crossing test:
    - end = cmd_addr + ((cmd_len+1) << cmd_size) − 1, computed at AW+1 bits.
    - The burst crosses if end[AW-1:12] ≠ cmd_addr[AW-1:12], or the carry bit is set.
  - Illegal command: no AW is issued; go to IDLE with done_valid, done_resp=2'b10, done_timeout=0.
  - Legal command: go to ADDR.
- **ADDR**
  - aw_valid=1; aw_* fields are held stable.
  - aw_valid && axi_awready: go to DATA and clear beat counter (9 bits).
- **DATA**
  - w_valid = dat_valid, w_data = dat_data, w_strb = dat_strb (combinational pass-through).
  - dat_ready = axi_wready.
  - A beat is counted on w_valid && axi_wready.
  - The beat with count==aw_len goes to RESP.
- **RESP**
  - b_ready=1.
  - On axi_bvalid: done_valid=1, done_resp=axi_bresp, txn_count+1, go to IDLE.
- **Outside the phases**
  - aw_valid, w_valid, dat_ready and b_ready are 0 outside ADDR, DATA and RESP respectively.
  - axi_bvalid outside RESP is ignored.
  - cmd_valid while not in IDLE is stalled (cmd_ready=0).
- **Timeout**
  - The counter clears on every state entry and every handshake.
  - It increments each cycle in ADDR/DATA/RESP.
  - When it reaches TIMEOUT (≠0): drop all valids/readies, done_valid=1, done_resp=2'b11, done_timeout=1, go to IDLE.
  - txn_count does not increment on timeout.
- **Reset**
  - State goes to IDLE; all outputs 0, including cmd_ready while resetn=0.
  - Reset mid-transaction aborts the transaction with no done pulse.

## Timing
- Command handshake at cycle T:
  - legal → aw_valid=1 at T+1.
  - illegal → done_valid=1 at T+1.
- AW handshake at cycle A: w_valid may assert in cycle A+1.
- Last W handshake at cycle L: b_ready=1 at L+1.
- B handshake at cycle R: done_valid=1 at R+1 for exactly one cycle; cmd_ready=1 at R+1.
- Earliest next command handshake is R+1.
- Minimum latency for a 1-beat command: T, T+1 (AW), T+2 (W), T+3 (B), done at T+4.
- done_resp and done_timeout are valid only with done_valid; they hold their value until the next done.
- Timeout fires in the cycle the counter equals TIMEOUT; done_valid follows in the next cycle.

## Test plan
- Single beat: addr 0x1000, len 0, size 3, INCR; all readies high → aw_valid at T+1, one W beat, done_valid at T+4 with resp 00, txn_count=1.
- 16-beat burst with axi_wready toggled 1/0 and dat_valid gaps → exactly 16 W handshakes, data order preserved, RESP entered only after beat 16.
- 4 KB violation: addr 0x0FF8, len 1, size 3, INCR → no aw_valid, done_resp=10 at T+1, txn_count unchanged. Same command with FIXED burst → issued normally.
- cmd_size=4 → rejected with resp 10. size 3, len 255, addr 0x0 → accepted (ends at 0x7FF).
- TIMEOUT=8 with axi_awready held low → aw_valid for 8 cycles then drops, done_resp=11, done_timeout=1.
- resetn pulsed low during DATA beat 3 → outputs 0 immediately, no done pulse; a new command completes normally after reset.
